// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared types and constants for the SRAM-like port arbiter
package sram_like_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    localparam logic [2:0] ARB_INST_SIZE = 3'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - one SRAM-like port; the requester side uses master, the responder side uses slave
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;

    modport master (
        output req, wr, wstrb, size, addr, wdata,
        input  addr_ok, rdata, data_ok
    );

    modport slave (
        input  req, wr, wstrb, size, addr, wdata,
        output addr_ok, rdata, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter_tag_fifo.sv
// rtl/sram_like_arbiter_tag_fifo.sv - arb_tag_fifo: in-order source tag FIFO with combinational full/empty
module arb_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - merges fetch and data SRAM-like ports onto one memory port; ARB_ROUND_ROBIN_EN selects round-robin ties
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_like_arbiter_if.slave   inst_if,
    sram_like_arbiter_if.slave   data_if,
    sram_like_arbiter_if.master  mem_if
);
    arb_state_e r_state;
    arb_state_e w_state_nxt;
    arb_src_e   r_lock_src;
    arb_src_e   w_grant_src;
    arb_src_e   w_tie_src;
    logic       w_mem_req;
    logic       w_accept;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [0:0] w_head;

`ifdef ARB_ROUND_ROBIN_EN
    arb_src_e r_last_src;

    always_ff @(posedge clk) begin
        if (!resetn)       r_last_src <= SRC_INST;
        else if (w_accept) r_last_src <= w_grant_src;
    end

    assign w_tie_src = (r_last_src == SRC_INST) ? SRC_DATA : SRC_INST;
`else
    // data requests belong to older instructions, so they win ties
    assign w_tie_src = SRC_DATA;
`endif

    always_comb begin
        w_grant_src = SRC_INST;
        w_state_nxt = r_state;
        if (r_state == ST_WAIT)               w_grant_src = r_lock_src;
        else if (inst_if.req && data_if.req)  w_grant_src = w_tie_src;
        else if (data_if.req)                 w_grant_src = SRC_DATA;

        w_mem_req = (inst_if.req || data_if.req) && !w_full && resetn;
        w_accept  = w_mem_req && mem_if.addr_ok;

        case (r_state)
            ST_IDLE: if (w_mem_req && !mem_if.addr_ok) w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_accept)                     w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_lock_src <= SRC_INST;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_WAIT) r_lock_src <= w_grant_src;
        end
    end

    assign mem_if.req   = w_mem_req;
    assign mem_if.wr    = (w_grant_src == SRC_DATA) ? data_if.wr    : 1'b0;
    assign mem_if.wstrb = (w_grant_src == SRC_DATA) ? data_if.wstrb : 4'h0;
    assign mem_if.size  = (w_grant_src == SRC_DATA) ? data_if.size  : ARB_INST_SIZE;
    assign mem_if.addr  = (w_grant_src == SRC_DATA) ? data_if.addr  : inst_if.addr;
    assign mem_if.wdata = (w_grant_src == SRC_DATA) ? data_if.wdata : 32'h0;

    assign inst_if.addr_ok = w_accept && (w_grant_src == SRC_INST);
    assign data_if.addr_ok = w_accept && (w_grant_src == SRC_DATA);

    // responses with no outstanding tag (e.g. issued before a reset) are dropped
    assign w_pop = mem_if.data_ok && !w_empty && resetn;

    arb_tag_fifo #(
        .WIDTH (1),
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_accept),
        .i_din   (1'(w_grant_src)),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign inst_if.data_ok = w_pop && (w_head == 1'(SRC_INST));
    assign data_if.data_ok = w_pop && (w_head == 1'(SRC_DATA));
    assign inst_if.rdata   = mem_if.rdata;
    assign data_if.rdata   = mem_if.rdata;

    always_ff @(posedge clk) begin
        assert (!(resetn && mem_if.data_ok && w_empty))
            else $error("sram_like_arbiter: mem_data_ok with no outstanding transaction");
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter with a queue-based reference model
module tb_sram_like_arbiter;
    logic clk = 1'b0;
    logic resetn;
    int   checks;
    int   failures;

    always #5 clk = ~clk;

    sram_like_arbiter_if ib ();
    sram_like_arbiter_if db ();
    sram_like_arbiter_if mb ();

    sram_like_arbiter #(.OUTSTANDING(4)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .inst_if (ib),
        .data_if (db),
        .mem_if  (mb)
    );

    task automatic idle_inputs;
        ib.req = 0; ib.wr = 0; ib.wstrb = 0; ib.size = 3'd2; ib.addr = 0; ib.wdata = 0;
        db.req = 0; db.wr = 0; db.wstrb = 0; db.size = 3'd2; db.addr = 0; db.wdata = 0;
        mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        idle_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
    endtask

    task automatic accept_inst(input logic [31:0] a);
        ib.req = 1; ib.addr = a; mb.addr_ok = 1;
        tick();
        ib.req = 0; mb.addr_ok = 0;
    endtask

    task automatic accept_data(input logic [31:0] a);
        db.req = 1; db.addr = a; db.wr = 0; mb.addr_ok = 1;
        tick();
        db.req = 0; mb.addr_ok = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        resetn = 0;
        ib.req = 1; db.req = 1; mb.addr_ok = 1; mb.data_ok = 1;
        tick();
        #2;
        checks++; if (mb.req !== 1'b0)     begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mb.req); end
        checks++; if (ib.addr_ok !== 1'b0) begin failures++; $display("FAIL reset_inst_addr_ok got=%b exp=0", ib.addr_ok); end
        checks++; if (db.addr_ok !== 1'b0) begin failures++; $display("FAIL reset_data_addr_ok got=%b exp=0", db.addr_ok); end
        checks++; if (ib.data_ok !== 1'b0) begin failures++; $display("FAIL reset_inst_data_ok got=%b exp=0", ib.data_ok); end
        checks++; if (db.data_ok !== 1'b0) begin failures++; $display("FAIL reset_data_data_ok got=%b exp=0", db.data_ok); end
        tick();
        idle_inputs();
        resetn = 1;
        ib.req = 1; ib.addr = 32'h1234;
        #2;
        checks++; if (mb.req !== 1'b1)          begin failures++; $display("FAIL post_reset_mem_req got=%b exp=1", mb.req); end
        checks++; if (mb.addr !== 32'h1234)     begin failures++; $display("FAIL post_reset_mem_addr got=%h exp=00001234", mb.addr); end
        tick();
    endtask

    task automatic test_tie;
        logic [31:0] e_addr;
        logic        e_iok;
        do_reset();
        ib.req = 1; ib.addr = 32'h40;
        db.req = 1; db.addr = 32'h100; db.wr = 1; db.wstrb = 4'h3; db.size = 3'd1; db.wdata = 32'h5555;
        mb.addr_ok = 1;
        #2;
        checks++; if (mb.addr !== 32'h100)  begin failures++; $display("FAIL tie0_mem_addr got=%h exp=00000100", mb.addr); end
        checks++; if (db.addr_ok !== 1'b1)  begin failures++; $display("FAIL tie0_data_addr_ok got=%b exp=1", db.addr_ok); end
        checks++; if (ib.addr_ok !== 1'b0)  begin failures++; $display("FAIL tie0_inst_addr_ok got=%b exp=0", ib.addr_ok); end
        checks++; if ({mb.wr, mb.wstrb, mb.size, mb.wdata} !== {1'b1, 4'h3, 3'd1, 32'h5555})
            begin failures++; $display("FAIL tie0_mem_fields got=%b/%h/%0d/%h exp=1/3/1/00005555", mb.wr, mb.wstrb, mb.size, mb.wdata); end
        tick();
        db.addr = 32'h104;
`ifdef ARB_ROUND_ROBIN_EN
        e_addr = 32'h40;  e_iok = 1'b1;
`else
        e_addr = 32'h104; e_iok = 1'b0;
`endif
        #2;
        checks++; if (mb.addr !== e_addr)   begin failures++; $display("FAIL tie1_mem_addr got=%h exp=%h", mb.addr, e_addr); end
        checks++; if (ib.addr_ok !== e_iok) begin failures++; $display("FAIL tie1_inst_addr_ok got=%b exp=%b", ib.addr_ok, e_iok); end
        checks++; if (db.addr_ok !== !e_iok) begin failures++; $display("FAIL tie1_data_addr_ok got=%b exp=%b", db.addr_ok, !e_iok); end
        tick();
        if (e_iok) ib.req = 0; else db.req = 0;
        #2;
        checks++; if (ib.addr_ok !== !e_iok) begin failures++; $display("FAIL tie2_inst_addr_ok got=%b exp=%b", ib.addr_ok, !e_iok); end
        checks++; if (mb.addr !== (e_iok ? 32'h104 : 32'h40)) begin failures++; $display("FAIL tie2_mem_addr got=%h", mb.addr); end
        if (!e_iok) begin
            checks++; if ({mb.wr, mb.wstrb, mb.size} !== {1'b0, 4'h0, 3'd2})
                begin failures++; $display("FAIL tie2_inst_fields got=%b/%h/%0d exp=0/0/2", mb.wr, mb.wstrb, mb.size); end
        end
        tick();
    endtask

    task automatic test_lock;
        do_reset();
        db.req = 1; db.addr = 32'h200; db.wr = 1; db.wstrb = 4'hF; db.wdata = 32'hDEAD;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin ib.req = 1; ib.addr = 32'h80; end
            #2;
            checks++; if (mb.req !== 1'b1 || mb.addr !== 32'h200)
                begin failures++; $display("FAIL lock_hold_data c=%0d got=%b/%h exp=1/00000200", c, mb.req, mb.addr); end
            checks++; if (ib.addr_ok !== 1'b0 || db.addr_ok !== 1'b0)
                begin failures++; $display("FAIL lock_no_ok c=%0d got=%b%b exp=00", c, ib.addr_ok, db.addr_ok); end
            tick();
        end
        mb.addr_ok = 1;
        #2;
        checks++; if (db.addr_ok !== 1'b1 || mb.wdata !== 32'hDEAD)
            begin failures++; $display("FAIL lock_release_data got=%b/%h exp=1/0000dead", db.addr_ok, mb.wdata); end
        tick();
        db.req = 0;
        #2;
        checks++; if (ib.addr_ok !== 1'b1 || mb.addr !== 32'h80)
            begin failures++; $display("FAIL lock_then_inst got=%b/%h exp=1/00000080", ib.addr_ok, mb.addr); end
        tick();
        do_reset();
        ib.req = 1; ib.addr = 32'h3C;
        tick();
        db.req = 1; db.addr = 32'h300;
        #2;
        checks++; if (mb.addr !== 32'h3C) begin failures++; $display("FAIL lock_inst_over_data got=%h exp=0000003c", mb.addr); end
        tick();
        mb.addr_ok = 1;
        #2;
        checks++; if (ib.addr_ok !== 1'b1 || db.addr_ok !== 1'b0)
            begin failures++; $display("FAIL lock_inst_release got=%b%b exp=10", ib.addr_ok, db.addr_ok); end
        tick();
    endtask

    task automatic test_ordering;
        logic [31:0] vals [3];
        bit          to_inst [3];
        vals = '{32'hA, 32'hB, 32'hC};
        to_inst = '{1'b1, 1'b0, 1'b1};
        do_reset();
        accept_inst(32'h0);
        accept_data(32'h200);
        accept_inst(32'h4);
        for (int i = 0; i < 3; i++) begin
            mb.data_ok = 1; mb.rdata = vals[i];
            #2;
            checks++; if (ib.data_ok !== to_inst[i] || db.data_ok !== !to_inst[i])
                begin failures++; $display("FAIL order_route i=%0d got=%b%b exp=%b%b", i, ib.data_ok, db.data_ok, to_inst[i], !to_inst[i]); end
            checks++; if ((to_inst[i] ? ib.rdata : db.rdata) !== vals[i])
                begin failures++; $display("FAIL order_rdata i=%0d got=%h exp=%h", i, (to_inst[i] ? ib.rdata : db.rdata), vals[i]); end
            tick();
        end
        mb.data_ok = 0;
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) accept_inst(32'(i * 4)); else accept_data(32'(i * 4));
        end
        db.req = 1; db.addr = 32'h300; mb.addr_ok = 1;
        #2;
        checks++; if (mb.req !== 1'b0 || db.addr_ok !== 1'b0)
            begin failures++; $display("FAIL full_block got=%b%b exp=00", mb.req, db.addr_ok); end
        tick();
        mb.data_ok = 1; mb.rdata = 32'h77;
        #2;
        checks++; if (mb.req !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%b exp=0", mb.req); end
        checks++; if (ib.data_ok !== 1'b1) begin failures++; $display("FAIL full_pop_inst got=%b exp=1", ib.data_ok); end
        tick();
        mb.data_ok = 0;
        #2;
        checks++; if (mb.req !== 1'b1 || db.addr_ok !== 1'b1 || mb.addr !== 32'h300)
            begin failures++; $display("FAIL full_resume got=%b/%b/%h exp=1/1/00000300", mb.req, db.addr_ok, mb.addr); end
        tick();
        idle_inputs();
    endtask

    task automatic test_concurrent;
        bit exp_data [4];
        exp_data = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        accept_inst(32'h10);
        accept_data(32'h20);
        ib.req = 1; ib.addr = 32'h30; mb.addr_ok = 1; mb.data_ok = 1; mb.rdata = 32'h11;
        #2;
        checks++; if (ib.addr_ok !== 1'b1 || ib.data_ok !== 1'b1 || db.data_ok !== 1'b0)
            begin failures++; $display("FAIL conc_accept_pop got=%b%b%b exp=110", ib.addr_ok, ib.data_ok, db.data_ok); end
        tick();
        ib.req = 0; mb.addr_ok = 0; mb.data_ok = 0;
        accept_data(32'h40);
        accept_inst(32'h50);
        db.req = 1; db.addr = 32'h60; mb.addr_ok = 1;
        #2;
        checks++; if (mb.req !== 1'b0) begin failures++; $display("FAIL conc_count_full got=%b exp=0", mb.req); end
        tick();
        db.req = 0; mb.addr_ok = 0;
        for (int i = 0; i < 4; i++) begin
            mb.data_ok = 1;
            #2;
            checks++; if (db.data_ok !== exp_data[i] || ib.data_ok !== !exp_data[i])
                begin failures++; $display("FAIL conc_head i=%0d got=%b%b exp=%b%b", i, ib.data_ok, db.data_ok, !exp_data[i], exp_data[i]); end
            tick();
        end
        mb.data_ok = 0;
    endtask

    task automatic test_reset_midop;
        do_reset();
        accept_inst(32'h0);
        accept_data(32'h4);
        ib.req = 1; ib.addr = 32'h8;
        tick();
        resetn = 0; mb.data_ok = 1;
        #2;
        checks++; if (ib.data_ok !== 1'b0 || db.data_ok !== 1'b0 || mb.req !== 1'b0)
            begin failures++; $display("FAIL midrst_outputs got=%b%b%b exp=000", ib.data_ok, db.data_ok, mb.req); end
        tick();
        resetn = 1; mb.data_ok = 0;
        db.req = 1; db.addr = 32'h100; mb.addr_ok = 1;
        #2;
        checks++; if (db.addr_ok !== 1'b1 || mb.addr !== 32'h100)
            begin failures++; $display("FAIL midrst_lock_clear got=%b/%h exp=1/00000100", db.addr_ok, mb.addr); end
        tick();
        ib.req = 0;
        for (int i = 1; i < 4; i++) begin
            db.addr = 32'h100 + 32'(i * 4);
            #2;
            checks++; if (db.addr_ok !== 1'b1) begin failures++; $display("FAIL midrst_count_clear i=%0d got=%b exp=1", i, db.addr_ok); end
            tick();
        end
        #2;
        checks++; if (mb.req !== 1'b0) begin failures++; $display("FAIL midrst_full got=%b exp=0", mb.req); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random;
        bit          q[$];
        bit          locked, lock_src, last_src, e_src, e_req, e_acc, e_iok, e_dok;
        logic [31:0] e_addr;
        logic [2:0]  e_size;
        do_reset();
        locked = 0; lock_src = 0; last_src = 0;
        for (int n = 0; n < 600; n++) begin
            if (!ib.req && $urandom_range(0, 2) == 0) begin
                ib.req = 1; ib.addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!db.req && $urandom_range(0, 2) == 0) begin
                db.req = 1; db.addr = $urandom; db.wr = 1'($urandom); db.wstrb = 4'($urandom);
                db.size = 3'($urandom_range(0, 2)); db.wdata = $urandom;
            end
            mb.addr_ok = 1'($urandom_range(0, 1));
            mb.data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            mb.rdata   = $urandom;

            e_req = (ib.req || db.req) && (q.size() < 4);
            if (locked)                  e_src = lock_src;
`ifdef ARB_ROUND_ROBIN_EN
            else if (ib.req && db.req)   e_src = !last_src;
`else
            else if (ib.req && db.req)   e_src = 1'b1;
`endif
            else                         e_src = db.req;
            e_acc  = e_req && mb.addr_ok;
            e_addr = e_src ? db.addr : ib.addr;
            e_size = e_src ? db.size : 3'd2;
            e_iok  = mb.data_ok && (q.size() > 0) && (q[0] == 1'b0);
            e_dok  = mb.data_ok && (q.size() > 0) && (q[0] == 1'b1);
            #2;
            checks++; if (mb.req !== e_req) begin failures++; $display("FAIL rnd_mem_req n=%0d got=%b exp=%b", n, mb.req, e_req); end
            if (e_req) begin
                checks++; if (mb.addr !== e_addr || mb.size !== e_size || mb.wr !== (e_src & db.wr))
                    begin failures++; $display("FAIL rnd_mem_fields n=%0d got=%h/%0d/%b exp=%h/%0d/%b", n, mb.addr, mb.size, mb.wr, e_addr, e_size, e_src & db.wr); end
            end
            checks++; if (ib.addr_ok !== (e_acc && !e_src) || db.addr_ok !== (e_acc && e_src))
                begin failures++; $display("FAIL rnd_addr_ok n=%0d got=%b%b exp=%b%b", n, ib.addr_ok, db.addr_ok, e_acc && !e_src, e_acc && e_src); end
            checks++; if (ib.data_ok !== e_iok || db.data_ok !== e_dok)
                begin failures++; $display("FAIL rnd_data_ok n=%0d got=%b%b exp=%b%b", n, ib.data_ok, db.data_ok, e_iok, e_dok); end
            if (e_iok || e_dok) begin
                checks++; if ((e_iok ? ib.rdata : db.rdata) !== mb.rdata)
                    begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, (e_iok ? ib.rdata : db.rdata), mb.rdata); end
            end
            tick();
            if (mb.data_ok && q.size() > 0) void'(q.pop_front());
            if (e_acc) begin
                q.push_back(e_src);
                last_src = e_src;
                locked = 0;
                if (e_src) db.req = 0; else ib.req = 0;
            end else if (e_req) begin
                locked = 1;
                lock_src = e_src;
            end
        end
        idle_inputs();
        do_reset();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        resetn = 0;
        idle_inputs();
        test_reset();
        test_tie();
        test_lock();
        test_ordering();
        test_full();
        test_concurrent();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
